count_stream_checker: RTL and testbench



---
 rtl/count_stream_checker_if.sv | 24 ++
 rtl/count_stream_checker.sv | 125 ++++++++++++
 tb/tb_count_stream_checker.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/count_stream_checker_if.sv
// Bundles the sampled counter stream, its control strobes and the checker's
// status outputs. The source side (master) drives the stream and clear; the
// checker (slave) drives lock/error status and the predicted next value.
interface count_stream_checker_if #(
   parameter int W = 8
);
   logic [W-1:0] din;
   logic         din_valid;
   logic         clear;
   logic         locked;
   logic         err;
   logic [7:0]   err_count;
   logic [W-1:0] expected;

   modport master (
      output din, din_valid, clear,
      input  locked, err, err_count, expected
   );

   modport slave (
      input  din, din_valid, clear,
      output locked, err, err_count, expected
   );
endinterface

// File: rtl/count_stream_checker.sv
// Receive-side checker for a free-running +1 (mod 2^W) counter stream.
// SEARCH: watches for LOCK_LEN consecutive incrementing samples.
// LOCKED: predicts each next word, pulses err and bumps a saturating tally on
// every mismatch, resyncs the prediction to the offending word, and drops back
// to SEARCH after LOSS_LEN consecutive mismatches.
module count_stream_checker #(
   parameter int W        = 8,
   parameter int LOCK_LEN = 4,
   parameter int LOSS_LEN = 2
) (
   input logic                   clk,
   input logic                   rst,
   count_stream_checker_if.slave bus
);

   // Run counters are 4 bits wide, enough for the 2..15 / 1..15 thresholds.
   localparam logic [3:0] LOCK_N = 4'(LOCK_LEN);
   localparam logic [3:0] LOSS_N = 4'(LOSS_LEN);

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t       state, state_nx;
   logic [W-1:0] prev, prev_nx;
   logic         have_prev, have_prev_nx;
   logic [3:0]   run, run_nx;
   logic [3:0]   miss_run, miss_nx;
   logic [W-1:0] pred, pred_nx;
   logic         err_pulse, err_nx;
   logic [7:0]   tally, tally_nx;

   logic [W-1:0] prev_inc;
   logic [W-1:0] din_inc;
   logic [W-1:0] pred_inc;

   // Error tally sticks at its maximum instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Next-state and next-register values; a cycle without a valid sample
   // holds everything except the err pulse, which falls back to 0.
   always_comb begin
      state_nx     = state;
      prev_nx      = prev;
      have_prev_nx = have_prev;
      run_nx       = run;
      miss_nx      = miss_run;
      pred_nx      = pred;
      err_nx       = 1'b0;
      tally_nx     = tally;
      // Increments are taken into W-bit variables so 2^W-1 -> 0 wraps.
      prev_inc     = prev + 1'b1;
      din_inc      = bus.din + 1'b1;
      pred_inc     = pred + 1'b1;

      if (bus.din_valid) begin
         unique case (state)
            SEARCH: begin
               if (have_prev && (bus.din == prev_inc)) run_nx = run + 4'd1;
               else                                    run_nx = 4'd1;
               prev_nx      = bus.din;
               have_prev_nx = 1'b1;
               if (run_nx == LOCK_N) begin
                  state_nx = LOCKED;
                  pred_nx  = din_inc;
                  miss_nx  = 4'd0;
                  run_nx   = 4'd0;
               end
            end
            LOCKED: begin
               if (bus.din == pred) begin
                  pred_nx = pred_inc;
                  miss_nx = 4'd0;
               end else begin
                  err_nx   = 1'b1;
                  tally_nx = sat_inc(tally);
                  pred_nx  = din_inc;
                  miss_nx  = miss_run + 4'd1;
                  if (miss_nx == LOSS_N) begin
                     // The offending word opens the next acquisition run.
                     state_nx     = SEARCH;
                     prev_nx      = bus.din;
                     have_prev_nx = 1'b1;
                     run_nx       = 4'd1;
                     miss_nx      = 4'd0;
                  end
               end
            end
            default: state_nx = SEARCH;
         endcase
      end

      // clear wins over a same-cycle increment.
      if (bus.clear) tally_nx = 8'd0;
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SEARCH;
         prev      <= '0;
         have_prev <= 1'b0;
         run       <= 4'd0;
         miss_run  <= 4'd0;
         pred      <= '0;
         err_pulse <= 1'b0;
         tally     <= 8'd0;
      end else begin
         state     <= state_nx;
         prev      <= prev_nx;
         have_prev <= have_prev_nx;
         run       <= run_nx;
         miss_run  <= miss_nx;
         pred      <= pred_nx;
         err_pulse <= err_nx;
         tally     <= tally_nx;
      end
   end

   assign bus.locked    = (state == LOCKED);
   assign bus.err       = err_pulse;
   assign bus.err_count = tally;
   assign bus.expected  = pred;

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed bench for count_stream_checker. Instance a uses default
// parameters; instance b (LOSS_LEN=15) shares the stimulus and is only
// examined in the saturation / clear scenario.
module tb_count_stream_checker;

   logic       clk;
   logic       rst;
   logic [7:0] din_s;
   logic       valid_s;
   logic       clear_s;

   int checks   = 0;
   int failures = 0;

   count_stream_checker_if #(.W(8)) bus_a ();
   count_stream_checker_if #(.W(8)) bus_b ();

   assign bus_a.din       = din_s;
   assign bus_a.din_valid = valid_s;
   assign bus_a.clear     = clear_s;
   assign bus_b.din       = din_s;
   assign bus_b.din_valid = valid_s;
   assign bus_b.clear     = clear_s;

   count_stream_checker #(.W(8), .LOCK_LEN(4), .LOSS_LEN(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   count_stream_checker #(.W(8), .LOCK_LEN(4), .LOSS_LEN(15)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present one word at the falling edge, then land 1 time unit after the
   // sampling edge so outputs reflect that word.
   task automatic step(input logic [7:0] d, input logic v, input logic c);
      @(negedge clk);
      din_s   = d;
      valid_s = v;
      clear_s = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      din_s   = 8'd0;
      valid_s = 1'b0;
      clear_s = 1'b0;
      rst     = 1'b0;

      // Reset state
      #2 rst = 1'b1;
      #1;
      chk("rst_locked",   bus_a.locked,    0);
      chk("rst_err",      bus_a.err,       0);
      chk("rst_count",    bus_a.err_count, 0);
      chk("rst_expected", bus_a.expected,  0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1. Acquisition on 0..9: locked from the cycle after 3 is sampled
      for (int i = 0; i < 10; i++) begin
         step(8'(i), 1'b1, 1'b0);
         chk("acq_locked", bus_a.locked, (i >= 3) ? 1 : 0);
         chk("acq_err",    bus_a.err,    0);
      end
      chk("acq_count",    bus_a.err_count, 0);
      chk("acq_expected", bus_a.expected,  10);

      // 2. Wrap: walk the prediction up to 0xFD, then cross 0xFF -> 0x00
      for (int v = 10; v <= 252; v++) step(8'(v), 1'b1, 1'b0);
      chk("pre_wrap_expected", bus_a.expected, 8'hFD);
      for (int k = 0; k < 5; k++) begin
         step(8'(253 + k), 1'b1, 1'b0);
         chk("wrap_err",    bus_a.err,    0);
         chk("wrap_locked", bus_a.locked, 1);
      end
      chk("wrap_expected", bus_a.expected, 8'h02);
      chk("wrap_count",    bus_a.err_count, 0);

      // 3. Single glitch at expected=10: 10,11,50,51,52
      for (int v = 2; v <= 9; v++) step(8'(v), 1'b1, 1'b0);
      step(8'd10, 1'b1, 1'b0);  chk("glitch_err_10", bus_a.err, 0);
      step(8'd11, 1'b1, 1'b0);  chk("glitch_err_11", bus_a.err, 0);
      step(8'd50, 1'b1, 1'b0);
      chk("glitch_err_50",    bus_a.err,       1);
      chk("glitch_count_50",  bus_a.err_count, 1);
      chk("glitch_locked_50", bus_a.locked,    1);
      step(8'd51, 1'b1, 1'b0);  chk("glitch_err_51", bus_a.err, 0);
      step(8'd52, 1'b1, 1'b0);  chk("glitch_err_52", bus_a.err, 0);
      chk("glitch_expected", bus_a.expected,  53);
      chk("glitch_count",    bus_a.err_count, 1);
      chk("glitch_locked",   bus_a.locked,    1);

      // 4. Loss and relock: clear the tally, bring prediction to 10,
      //    then 10,11,30,90,91,92,93
      for (int j = 53; j < 266; j++) step(8'(j), 1'b1, 1'b0);
      step(8'd0, 1'b0, 1'b1);
      chk("clear_idle_count",    bus_a.err_count, 0);
      chk("clear_idle_expected", bus_a.expected,  10);
      step(8'd10, 1'b1, 1'b0);  chk("loss_err_10", bus_a.err, 0);
      step(8'd11, 1'b1, 1'b0);  chk("loss_err_11", bus_a.err, 0);
      step(8'd30, 1'b1, 1'b0);
      chk("loss_err_30",      bus_a.err,       1);
      chk("loss_count_30",    bus_a.err_count, 1);
      chk("loss_locked_30",   bus_a.locked,    1);
      chk("loss_expected_30", bus_a.expected,  31);
      step(8'd90, 1'b1, 1'b0);
      chk("loss_err_90",    bus_a.err,       1);
      chk("loss_count_90",  bus_a.err_count, 2);
      chk("loss_locked_90", bus_a.locked,    0);
      step(8'd91, 1'b1, 1'b0);
      chk("relock_err_91",    bus_a.err,    0);
      chk("relock_locked_91", bus_a.locked, 0);
      step(8'd92, 1'b1, 1'b0);
      chk("relock_locked_92", bus_a.locked, 0);
      step(8'd93, 1'b1, 1'b0);
      chk("relock_locked_93",   bus_a.locked,    1);
      chk("relock_expected_93", bus_a.expected,  94);
      chk("relock_count_93",    bus_a.err_count, 2);

      // 5. Valid gaps at expected=5, then asynchronous reset between edges
      for (int j = 94; j < 261; j++) step(8'(j), 1'b1, 1'b0);
      step(8'd5, 1'b1, 1'b0);
      chk("gap_err_5",      bus_a.err,      0);
      chk("gap_expected_5", bus_a.expected, 6);
      for (int k = 0; k < 3; k++) begin
         step(8'd77, 1'b0, 1'b0);
         chk("gap_idle_err",      bus_a.err,      0);
         chk("gap_idle_locked",   bus_a.locked,   1);
         chk("gap_idle_expected", bus_a.expected, 6);
      end
      step(8'd6, 1'b1, 1'b0);
      chk("gap_err_6",      bus_a.err,      0);
      chk("gap_expected_6", bus_a.expected, 7);
      #2 rst = 1'b1;
      #1;
      chk("arst_locked",   bus_a.locked,    0);
      chk("arst_err",      bus_a.err,       0);
      chk("arst_count",    bus_a.err_count, 0);
      chk("arst_expected", bus_a.expected,  0);
      @(negedge clk);
      rst = 1'b0;

      // 6. Saturation and clear on the LOSS_LEN=15 instance
      for (int i = 0; i < 4; i++) step(8'(i), 1'b1, 1'b0);
      chk("sat_lock",          bus_b.locked,   1);
      chk("sat_lock_expected", bus_b.expected, 4);
      for (int v = 4; v <= 255; v++) step(8'(v), 1'b1, 1'b0);
      chk("sat_pre_expected", bus_b.expected, 0);
      // Mostly zeros; every 15th sample drives the predicted value 1 so the
      // mismatch run never reaches 15. 307 mismatches in total.
      for (int i = 0; i < 330; i++) step((i % 15 == 14) ? 8'd1 : 8'd0, 1'b1, 1'b0);
      chk("sat_count",    bus_b.err_count, 255);
      chk("sat_locked",   bus_b.locked,    1);
      chk("sat_expected", bus_b.expected,  2);
      step(8'd0, 1'b1, 1'b1);
      chk("clear_mm_count", bus_b.err_count, 0);
      chk("clear_mm_err",   bus_b.err,       1);
      step(8'd0, 1'b1, 1'b0);
      chk("post_clear_count",  bus_b.err_count, 1);
      chk("post_clear_err",    bus_b.err,       1);
      chk("post_clear_locked", bus_b.locked,    1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
